// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch: PC generation, 1-cycle imem requests, output FIFO, redirect/flush
// Optional perf counters enabled by defining FETCH_PERF_EN.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   pc;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic [31:0]   fifo_inst [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic          pop;
    logic          push;
    logic          issue;
    logic          unused_pc_lsbs;

    assign unused_pc_lsbs = ^redirect_pc[1:0];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en)  state_nxt = RUN;
            RUN:     if (!en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Slots reserved = stored entries plus the word still coming back from memory.
    always_comb begin
        occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
        pop       = (count != '0) && inst_ready;
        push      = inflight && !redirect_valid;
        issue     = (state == RUN) && en && !redirect_valid &&
                    ((occupancy < (CW+1)'(DEPTH)) || pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
        end else begin
            state <= state_nxt;
            if (redirect_valid) begin
                pc       <= {redirect_pc[31:2], 2'b00};
                inflight <= 1'b0;
                wptr     <= '0;
                rptr     <= '0;
                count    <= '0;
            end else begin
                if (issue) begin
                    pc          <= pc + 32'd4;
                    inflight_pc <= pc;
                end
                inflight <= issue;
                if (push) wptr <= wptr + 1'b1;
                if (pop)  rptr <= rptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wptr] <= imem_rdata;
            fifo_pc[wptr]   <= inflight_pc;
        end
    end

    assign imem_req   = issue;
    assign imem_addr  = pc;
    assign inst_valid = (count != '0);
    // Gate the head to zero when empty so stale entries never leak out.
    assign inst_out   = inst_valid ? fifo_inst[rptr] : 32'h0;
    assign pc_out     = inst_valid ? fifo_pc[rptr]   : 32'h0;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (pop)                      perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (inst_valid && !inst_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && (count == CW'(DEPTH)) && !pop));

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_ready;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] pc_out;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic [31:0] w_out;
    logic [31:0] w_pc;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] w_perf_fetch;
    logic [31:0] w_perf_stall;
`endif

    int checks = 0;
    int errors = 0;

    inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .en(en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_out(inst_out), .pc_out(pc_out)
`ifdef FETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
        .clk(clk), .rst(rst), .en(en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
        .inst_valid(w_valid), .inst_ready(inst_ready),
        .inst_out(w_out), .pc_out(w_pc)
`ifdef FETCH_PERF_EN
        , .perf_fetch_cnt(w_perf_fetch), .perf_stall_cnt(w_perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        imem_rdata <= imem_addr + 32'h1000_0000;
        w_rdata    <= w_addr + 32'h1000_0000;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0; en = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        step; step;
        rst = 1'b1; en = 1'b1; inst_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0; en = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        step; step;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
        checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", inst_out); end
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out: got %h expected 0", pc_out); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
        checks++; if (w_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_wrap_addr: got %h expected fffffff8", w_addr); end
`ifdef FETCH_PERF_EN
        checks++; if (perf_fetch_cnt !== 32'h0) begin errors++; $display("FAIL reset_perf_fetch: got %h expected 0", perf_fetch_cnt); end
        checks++; if (perf_stall_cnt !== 32'h0) begin errors++; $display("FAIL reset_perf_stall: got %h expected 0", perf_stall_cnt); end
`endif
    endtask

    task automatic test_stream;
        do_reset;
        step;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL stream_first_req: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
        step;
        checks++; if (inst_valid !== 1'b0 || imem_addr !== 32'h4) begin errors++; $display("FAIL stream_second: got valid=%b addr=%h expected valid=0 addr=4", inst_valid, imem_addr); end
        step;
        checks++; if (inst_valid !== 1'b1 || pc_out !== 32'h0 || inst_out !== 32'h1000_0000) begin errors++; $display("FAIL stream_first_out: got v=%b pc=%h inst=%h expected v=1 pc=0 inst=10000000", inst_valid, pc_out, inst_out); end
        for (int k = 1; k <= 5; k++) begin
            step;
            checks++; if (inst_valid !== 1'b1 || pc_out !== 32'(4*k) || inst_out !== 32'(4*k) + 32'h1000_0000) begin errors++; $display("FAIL stream_out_%0d: got v=%b pc=%h inst=%h expected pc=%h", k, inst_valid, pc_out, inst_out, 32'(4*k)); end
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4*k + 8)) begin errors++; $display("FAIL stream_req_%0d: got req=%b addr=%h expected req=1 addr=%h", k, imem_req, imem_addr, 32'(4*k + 8)); end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hC; exp_pc[1] = 32'h10; exp_pc[2] = 32'h14;
        do_reset;
        repeat (5) step;
        checks++; if (pc_out !== 32'h8) begin errors++; $display("FAIL bp_start: got pc=%h expected 8", pc_out); end
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step;
            checks++; if (inst_valid !== 1'b1 || pc_out !== 32'h8 || imem_req !== 1'b0) begin errors++; $display("FAIL bp_hold_%0d: got v=%b pc=%h req=%b expected v=1 pc=8 req=0", i, inst_valid, pc_out, imem_req); end
        end
        inst_ready = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL bp_resume_req: got req=%b addr=%h expected req=1 addr=10", imem_req, imem_addr); end
        for (int i = 0; i < 3; i++) begin
            step;
            checks++; if (inst_valid !== 1'b1 || pc_out !== exp_pc[i] || inst_out !== exp_pc[i] + 32'h1000_0000) begin errors++; $display("FAIL bp_drain_%0d: got v=%b pc=%h inst=%h expected pc=%h", i, inst_valid, pc_out, inst_out, exp_pc[i]); end
        end
    endtask

    task automatic test_redirect;
        do_reset;
        repeat (5) step;
        inst_ready = 1'b0;
        step; step;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        step;
        redirect_valid = 1'b0; inst_ready = 1'b1;
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got valid=%b expected 0", inst_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL redir_req: got req=%b addr=%h expected req=1 addr=100", imem_req, imem_addr); end
        step;
        checks++; if (inst_valid !== 1'b0 || imem_addr !== 32'h104) begin errors++; $display("FAIL redir_second: got v=%b addr=%h expected v=0 addr=104", inst_valid, imem_addr); end
        step;
        checks++; if (inst_valid !== 1'b1 || pc_out !== 32'h100 || inst_out !== 32'h1000_0100) begin errors++; $display("FAIL redir_first_out: got v=%b pc=%h inst=%h expected pc=100 inst=10000100", inst_valid, pc_out, inst_out); end
        step;
        checks++; if (inst_valid !== 1'b1 || pc_out !== 32'h104) begin errors++; $display("FAIL redir_next_out: got v=%b pc=%h expected pc=104", inst_valid, pc_out); end
    endtask

    task automatic test_back_to_back;
        do_reset;
        repeat (5) step;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL b2b_req_suppressed: got %b expected 0", imem_req); end
        step;
        redirect_pc = 32'h300;
        #1;
        checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL b2b_mid: got v=%b req=%b expected v=0 req=0", inst_valid, imem_req); end
        step;
        redirect_valid = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin errors++; $display("FAIL b2b_last_wins: got v=%b req=%b addr=%h expected v=0 req=1 addr=300", inst_valid, imem_req, imem_addr); end
        step;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap: got valid=%b expected 0", inst_valid); end
        step;
        checks++; if (inst_valid !== 1'b1 || pc_out !== 32'h300 || inst_out !== 32'h1000_0300) begin errors++; $display("FAIL b2b_out: got v=%b pc=%h inst=%h expected pc=300 inst=10000300", inst_valid, pc_out, inst_out); end
        step;
        checks++; if (inst_valid !== 1'b1 || pc_out !== 32'h304) begin errors++; $display("FAIL b2b_next: got v=%b pc=%h expected pc=304", inst_valid, pc_out); end
    endtask

    task automatic test_halt;
        do_reset;
        step; step;
        en = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL halt_req_drop: got %b expected 0", imem_req); end
        step;
        checks++; if (inst_valid !== 1'b1 || pc_out !== 32'h0 || inst_out !== 32'h1000_0000) begin errors++; $display("FAIL halt_inflight_delivered: got v=%b pc=%h inst=%h expected pc=0 inst=10000000", inst_valid, pc_out, inst_out); end
        step;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL halt_drained: got valid=%b expected 0", inst_valid); end
        for (int i = 0; i < 3; i++) begin
            step;
            checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL halt_idle_%0d: got req=%b v=%b expected 0 0", i, imem_req, inst_valid); end
        end
        en = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL halt_idle_gate: got req=%b expected 0", imem_req); end
        step;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL halt_resume: got req=%b addr=%h expected req=1 addr=4", imem_req, imem_addr); end
        step; step;
        checks++; if (inst_valid !== 1'b1 || pc_out !== 32'h4 || inst_out !== 32'h1000_0004) begin errors++; $display("FAIL halt_resume_out: got v=%b pc=%h inst=%h expected pc=4 inst=10000004", inst_valid, pc_out, inst_out); end
    endtask

    task automatic test_wrap_reset;
        logic [31:0] exp_addr [4];
        exp_addr[0] = 32'hFFFF_FFF8; exp_addr[1] = 32'hFFFF_FFFC;
        exp_addr[2] = 32'h0;         exp_addr[3] = 32'h4;
        do_reset;
        for (int k = 0; k < 4; k++) begin
            step;
            checks++; if (w_req !== 1'b1 || w_addr !== exp_addr[k]) begin errors++; $display("FAIL wrap_addr_%0d: got req=%b addr=%h expected req=1 addr=%h", k, w_req, w_addr, exp_addr[k]); end
        end
        checks++; if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC || w_out !== 32'h0FFF_FFFC) begin errors++; $display("FAIL wrap_out: got v=%b pc=%h inst=%h expected pc=fffffffc inst=0ffffffc", w_valid, w_pc, w_out); end
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst_out !== 32'h0 || pc_out !== 32'h0) begin errors++; $display("FAIL midreset_main: got req=%b v=%b inst=%h pc=%h expected all 0", imem_req, inst_valid, inst_out, pc_out); end
        checks++; if (w_req !== 1'b0 || w_valid !== 1'b0 || w_out !== 32'h0 || w_pc !== 32'h0 || w_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL midreset_wrap: got req=%b v=%b inst=%h pc=%h addr=%h expected 0 0 0 0 fffffff8", w_req, w_valid, w_out, w_pc, w_addr); end
        step;
        rst = 1'b1;
        step;
        checks++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL midreset_restart: got req=%b addr=%h expected req=1 addr=fffffff8", w_req, w_addr); end
        step; step;
        checks++; if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFF8) begin errors++; $display("FAIL midreset_first_out: got v=%b pc=%h expected pc=fffffff8", w_valid, w_pc); end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf;
        do_reset;
        repeat (3) step;
        repeat (7) step;
        inst_ready = 1'b0;
        repeat (3) step;
        inst_ready = 1'b1;
        repeat (3) step;
        checks++; if (perf_fetch_cnt !== 32'd10) begin errors++; $display("FAIL perf_fetch: got %0d expected 10", perf_fetch_cnt); end
        checks++; if (perf_stall_cnt !== 32'd3) begin errors++; $display("FAIL perf_stall: got %0d expected 3", perf_stall_cnt); end
    endtask
`endif

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_redirect;
        test_back_to_back;
        test_halt;
        test_wrap_reset;
`ifdef FETCH_PERF_EN
        test_perf;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage directly upstream of the MAIN datapath.
- Generates the PC and issues read requests to a synchronous instruction memory with 1-cycle latency.
- Buffers returned words in a small FIFO and presents them downstream on a valid/ready handshake. inst_out drives MAIN dataIN; inst_valid qualifies MAIN en.
- Handles stalls, halts via en, and control-flow redirects with flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0).
- DEPTH, 2, output FIFO entries (minimum 2; power of 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- en  in  1  fetch enable; 0 halts new requests.
- redirect_valid  in  1  load new PC and flush.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0).
- imem_req  out  1  read request this cycle.
- imem_addr  out  32  word-aligned read address (= pc).
- imem_rdata  in  32  read data, valid the cycle after imem_req.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  downstream accepts head.
- inst_out  out  32  instruction at FIFO head.
- pc_out  out  32  address of inst_out.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, state=IDLE, FIFO empty, inflight=0.
  - imem_req=0, inst_valid=0, inst_out=0, pc_out=0.
- States:
  - IDLE: no requests; goes to RUN on the first clock edge with en=1.
  - RUN: returns to IDLE on any edge with en=0.
  - Requests already in flight still complete into the FIFO in IDLE. The FIFO keeps draining in IDLE.
- Issue rule (combinational):
  - imem_req = state==RUN && en && !redirect_valid && (count+inflight < DEPTH || pop).
  - pop = inst_valid && inst_ready.
  - Full throughput of one instruction per cycle is required with inst_ready held at 1.
- On issue:
  - imem_addr=pc; inflight<=1; inflight_pc<=pc; pc<=pc+4.
  - Wraps 32'hFFFF_FFFC -> 0.
  - Without issue, inflight<=0.
- Response: if inflight && !drop, push {inflight_pc, imem_rdata} into the FIFO next edge. Push and pop in the same cycle is legal at any occupancy, including full.
- Redirect (priority over push/pop/issue):
  - On the edge with redirect_valid=1: pc<={redirect_pc[31:2],2'b00}, FIFO cleared, inflight<=0.
  - Any response arriving that cycle is discarded.
  - A pop handshake completing in the redirect cycle counts as consumed.
  - The first request from the new pc issues the following cycle if the issue rule holds.
  - inst_valid=0 the cycle after redirect.
  - Back-to-back redirects: the last one wins.
- Outputs:
  - inst_valid = FIFO non-empty; inst_out/pc_out = head.
  - Head must stay stable while inst_valid && !inst_ready.
- Overflow is impossible by construction. An assertion must fire if a push occurs with count==DEPTH and no pop.
- Reset mid-operation: immediate return to reset values; in-flight responses are ignored.

Optional Feature:
- FETCH_PERF_EN defined:
  - Adds outputs perf_fetch_cnt[31:0] (increments on each pop) and perf_stall_cnt[31:0] (increments each cycle inst_valid && !inst_ready).
  - Both reset to 0, wrap at 2^32, and are cleared by reset only.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Memory model for all scenarios: imem_rdata = addr + 32'h1000_0000 of the previous cycle's request.
- Reset release, en=1, inst_ready=1: imem_addr 0,4,8,...; first inst_valid 2 cycles after first req with inst_out=32'h1000_0000, pc_out=0; one instruction per cycle thereafter.
- Backpressure: inst_ready=0 for 5 cycles after pc_out=8 appears -> at most DEPTH entries held, imem_req drops to 0, head stays pc_out=8; on ready=1, 8,C,10 emerge in order with no gaps or duplicates.
- Redirect: redirect_valid=1, redirect_pc=32'h0000_0103 while FIFO is full -> next cycle inst_valid=0; next imem_addr=32'h100; first output pc_out=32'h100, inst_out=32'h1000_0100; no stale addresses appear.
- Halt: en=0 with one request in flight -> that word is still delivered; no further imem_req; state IDLE; en=1 resumes at the next sequential address.
- Wrap/reset: RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0, 4. Assert rst=0 mid-stream -> all outputs 0 immediately, pc restarts at RESET_PC.
- With FETCH_PERF_EN: 10 pops and 3 stall cycles -> perf_fetch_cnt=10, perf_stall_cnt=3.
